// File: rtl/rf_pkg.sv
// Shared sizing defaults and requester identifiers for the register-file write arbiter.
package rf_pkg;
  localparam int RF_NREQ = 3;
  localparam int RF_DW   = 8;
  localparam int RF_AW   = 3;
  localparam int GIDW    = 2;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_MOV = 2;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-request, register-file write and scoreboard signals of the write arbiter.
// Handshake: requester i transfers when req_valid[i] and req_ready[i] are both high at a rising clk edge.
interface rf_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [GIDW-1:0]    grant_id;
  logic               sb_lock;
  logic [AW-1:0]      sb_lock_addr;
  logic [2**AW-1:0]   sb_busy;

  modport master (
    output req_valid, req_addr, req_data, sb_lock, sb_lock_addr,
    input  req_ready, rf_we, rf_waddr, rf_wdata, grant_id, sb_busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, sb_lock, sb_lock_addr,
    output req_ready, rf_we, rf_waddr, rf_wdata, grant_id, sb_busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans from last_grant+1 upward modulo NREQ.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = RF_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  logic [GIDW-1:0] last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [GIDW-1:0] gnt_idx,
  output logic            gnt_any
);
  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_grant) + k) % NREQ;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = GIDW'(j);
      end
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: one holding slot per requester, round-robin drain, registered rf_* outputs.
// Optional pending-write scoreboard enabled by defining RF_WARB_SCOREBOARD_EN.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input logic clk,
  input logic reset,
  rf_write_arbiter_if.slave bus
);
  logic [NREQ-1:0] slot_v;
  logic [AW-1:0]   slot_a [NREQ];
  logic [DW-1:0]   slot_d [NREQ];
  logic [GIDW-1:0] last_grant;

  logic [NREQ-1:0] gnt;
  logic [GIDW-1:0] gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] accept;

  logic            rf_we_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [DW-1:0]   rf_wdata_q;
  logic [GIDW-1:0] grant_id_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (slot_v),
    .last_grant(last_grant),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  // A slot being drained this cycle can be refilled at the same edge.
  assign bus.req_ready = ~slot_v | gnt;
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_v     <= '0;
      last_grant <= GIDW'(NREQ - 1);
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_a[i] <= '0;
        slot_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          slot_v[i] <= 1'b1;
          slot_a[i] <= bus.req_addr[i*AW +: AW];
          slot_d[i] <= bus.req_data[i*DW +: DW];
        end else if (gnt[i]) begin
          slot_v[i] <= 1'b0;
        end
      end
      rf_we_q <= gnt_any;
      if (gnt_any) begin
        rf_waddr_q <= slot_a[gnt_idx];
        rf_wdata_q <= slot_d[gnt_idx];
        grant_id_q <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.grant_id = grant_id_q;

`ifdef RF_WARB_SCOREBOARD_EN
  logic [2**AW-1:0] sb_q;
  logic [2**AW-1:0] sb_set;
  logic [2**AW-1:0] sb_clr;

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (bus.sb_lock) sb_set[bus.sb_lock_addr] = 1'b1;
    if (gnt_any)     sb_clr[slot_a[gnt_idx]]  = 1'b1;
  end

  // A lock issued on the same edge as the retiring write wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb_q <= '0;
    else       sb_q <= (sb_q & ~sb_clr) | sb_set;
  end

  assign bus.sb_busy = sb_q;
`else
  logic sb_unused;
  assign sb_unused   = ^{bus.sb_lock, bus.sb_lock_addr};
  assign bus.sb_busy = '0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a slot/queue reference model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int EW   = GIDW + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  bit             m_occ  [NREQ];
  logic [AW-1:0]  m_addr [NREQ];
  logic [DW-1:0]  m_data [NREQ];
  int             m_last;
  logic [2**AW-1:0] m_busy;
  logic [EW-1:0]  exp_q[$];
  logic [AW-1:0]  last_waddr;
  logic [DW-1:0]  last_wdata;
  logic [GIDW-1:0] last_gid;
  int             gid_trace[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_occ[i]  = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_last     = NREQ - 1;
    m_busy     = '0;
    exp_q.delete();
    last_waddr = '0;
    last_wdata = '0;
    last_gid   = '0;
  endtask

  task automatic idle_inputs();
    bus.req_valid    = '0;
    bus.req_addr     = '0;
    bus.req_data     = '0;
    bus.sb_lock      = 1'b0;
    bus.sb_lock_addr = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]         = 1'b1;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  // One clock: check ready against the model, advance the model at the edge, check rf_* after it.
  task automatic step();
    int g;
    logic [NREQ-1:0] rdy;
    logic [EW-1:0] e;
    g = -1;
    for (int k = 1; k <= NREQ; k++)
      if (g < 0 && m_occ[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
    for (int i = 0; i < NREQ; i++) rdy[i] = !m_occ[i] || (g == i);
    #1;
    check("req_ready", 32'(bus.req_ready), 32'(rdy));
    @(posedge clk);
    if (g >= 0) begin
      exp_q.push_back({GIDW'(g), m_addr[g], m_data[g]});
      m_occ[g] = 1'b0;
      m_last   = g;
`ifdef RF_WARB_SCOREBOARD_EN
      m_busy[m_addr[g]] = 1'b0;
`endif
    end
`ifdef RF_WARB_SCOREBOARD_EN
    if (bus.sb_lock) m_busy[bus.sb_lock_addr] = 1'b1;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && rdy[i]) begin
        m_occ[i]  = 1'b1;
        m_addr[i] = bus.req_addr[i*AW +: AW];
        m_data[i] = bus.req_data[i*DW +: DW];
      end
    end
    #1;
    if (exp_q.size() > 0) begin
      e          = exp_q.pop_front();
      last_gid   = e[DW+AW +: GIDW];
      last_waddr = e[DW +: AW];
      last_wdata = e[DW-1:0];
      check("rf_we", 32'(bus.rf_we), 32'd1);
      gid_trace.push_back(int'(bus.grant_id));
    end else begin
      check("rf_we", 32'(bus.rf_we), 32'd0);
    end
    check("rf_waddr", 32'(bus.rf_waddr), 32'(last_waddr));
    check("rf_wdata", 32'(bus.rf_wdata), 32'(last_wdata));
    check("grant_id", 32'(bus.grant_id), 32'(last_gid));
    check("sb_busy", 32'(bus.sb_busy), 32'(m_busy));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(bus.rf_we),     32'd0);
    check({tag, "_waddr"}, 32'(bus.rf_waddr),  32'd0);
    check({tag, "_wdata"}, 32'(bus.rf_wdata),  32'd0);
    check({tag, "_gid"},   32'(bus.grant_id),  32'd0);
    check({tag, "_busy"},  32'(bus.sb_busy),   32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'h7);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    model_reset();
    #2;
    do_reset();

    // Single write: visible two edges after acceptance, for exactly one cycle.
    set_req(REQ_ALU, 3'd3, 8'h5A);
    step();
    check("s1_we_early", 32'(bus.rf_we), 32'd0);
    idle_inputs();
    step();
    check("s1_we",    32'(bus.rf_we),    32'd1);
    check("s1_waddr", 32'(bus.rf_waddr), 32'd3);
    check("s1_wdata", 32'(bus.rf_wdata), 32'h5A);
    check("s1_gid",   32'(bus.grant_id), 32'd0);
    step();
    check("s1_we_off", 32'(bus.rf_we), 32'd0);

    // All requesters streaming: grants rotate 0,1,2,...
    do_reset();
    gid_trace.delete();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, AW'($urandom_range(0, 7)), DW'((i << 4) | c));
      step();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) step();
    check("s2_count", 32'(gid_trace.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < gid_trace.size(); k++)
      check("s2_order", 32'(gid_trace[k]), 32'(k % 3));

    // Same destination from two requesters: serialized, nothing dropped.
    do_reset();
    set_req(REQ_MEM, 3'd5, 8'h11);
    set_req(REQ_MOV, 3'd5, 8'h22);
    step();
    idle_inputs();
    step();
    check("s3_we0",    32'(bus.rf_we),    32'd1);
    check("s3_waddr0", 32'(bus.rf_waddr), 32'd5);
    check("s3_wdata0", 32'(bus.rf_wdata), 32'h11);
    check("s3_gid0",   32'(bus.grant_id), 32'd1);
    step();
    check("s3_we1",    32'(bus.rf_we),    32'd1);
    check("s3_waddr1", 32'(bus.rf_waddr), 32'd5);
    check("s3_wdata1", 32'(bus.rf_wdata), 32'h22);
    check("s3_gid1",   32'(bus.grant_id), 32'd2);
    step();
    check("s3_we_off", 32'(bus.rf_we), 32'd0);

`ifdef RF_WARB_SCOREBOARD_EN
    // Scoreboard set, clear at grant, and set-wins on collision.
    do_reset();
    bus.sb_lock = 1'b1; bus.sb_lock_addr = 3'd4;
    step();
    idle_inputs();
    check("s4_lock", 32'(bus.sb_busy), 32'h10);
    set_req(REQ_MEM, 3'd4, 8'h44);
    step();
    idle_inputs();
    step();
    check("s4_clear", 32'(bus.sb_busy), 32'h00);
    set_req(REQ_MEM, 3'd4, 8'h45);
    step();
    idle_inputs();
    bus.sb_lock = 1'b1; bus.sb_lock_addr = 3'd4;
    step();
    idle_inputs();
    check("s4_collide", 32'(bus.sb_busy), 32'h10);
`endif

    // Reset with all slots full: contents dropped, no write after release.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(8'hA0 + i));
    bus.sb_lock = 1'b1; bus.sb_lock_addr = 3'd6;
    step();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    check("s5_we",   32'(bus.rf_we),   32'd0);
    check("s5_busy", 32'(bus.sb_busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("s5_no_write", 32'(bus.rf_we), 32'd0);
    end

    // Random traffic including random scoreboard locks.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 99) < 60)
          set_req(i, AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      bus.sb_lock      = 1'($urandom_range(0, 1));
      bus.sb_lock_addr = AW'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    for (int c = 0; c < 5; c++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3: number of write requesters (ALU, memory load, immediate move).
REQ-002 The block SHALL have parameter DW, default 8: register data width.
REQ-003 The block SHALL have parameter AW, default 3: register address width (8 registers).
REQ-004 The block SHALL have port clk  in  1: single clock, all state updates on rising edge.
REQ-005 The block SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid  in  NREQ: per-requester write request.
REQ-007 The block SHALL have port req_ready  out  NREQ: per-requester accept; a transfer occurs when valid and ready are both high at a rising edge.
REQ-008 The block SHALL have port req_addr  in  NREQ*AW: per-requester destination register, packed with requester 0 in the LSBs.
REQ-009 The block SHALL have port req_data  in  NREQ*DW: per-requester write data, packed with requester 0 in the LSBs.
REQ-010 The block SHALL have port rf_we  out  1: registered write enable to the register file.
REQ-011 The block SHALL have port rf_waddr  out  AW: registered write address.
REQ-012 The block SHALL have port rf_wdata  out  DW: registered write data.
REQ-013 The block SHALL have port grant_id  out  2: registered index of the requester whose write is on rf_*.
REQ-014 The block SHALL have port sb_lock  in  1: at issue, marks register sb_lock_addr as pending-write.
REQ-015 The block SHALL have port sb_lock_addr  in  AW: register to mark busy.
REQ-016 The block SHALL have port sb_busy  out  2**AW: registered per-register pending-write bits.

Function
REQ-017 Each requester SHALL own a one-entry holding slot (valid, addr, data).
REQ-018 req_ready[i] SHALL equal (slot i empty) OR (slot i granted this cycle), so that a requester can stream one write per cycle while it is being granted.
REQ-019 At each edge, the arbiter SHALL select one occupied slot round-robin, scanning from last_grant+1 upward modulo NREQ.
REQ-020 At each edge, the selected slot's addr and data SHALL be loaded into rf_waddr and rf_wdata, rf_we SHALL be set to 1, grant_id SHALL be set to the slot index, last_grant SHALL be updated, and the slot SHALL be freed unless it is refilled at the same edge.
REQ-021 When no slot is occupied, rf_we SHALL be 0 at the next edge; rf_waddr, rf_wdata and grant_id SHALL hold their values.
REQ-022 Latency SHALL be as follows: a request accepted at edge k is earliest on rf_* after edge k+1 (2 edges); rf_we SHALL never be high for more than one cycle per accepted request.
REQ-023 Two requesters targeting the same address SHALL be serialized in grant order, with no merging or dropping.
REQ-024 When all slots are full and none is granted, the corresponding req_ready bits SHALL be 0; no request SHALL ever be lost or duplicated.
REQ-025 Starvation bound: an occupied slot SHALL be granted within NREQ cycles.

Reset
REQ-026 While reset is high, all slots SHALL be empty, rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, sb_busy=0, and last_grant=NREQ-1 (requester 0 has first priority).
REQ-027 Reset asserted mid-operation SHALL drop pending slot contents immediately, with no write after reset release until a new request is accepted.

Configuration
REQ-028 With macro RF_WARB_SCOREBOARD_EN defined, sb_lock SHALL set sb_busy[sb_lock_addr], and a grant SHALL clear sb_busy[granted addr] at the same edge.
REQ-029 With RF_WARB_SCOREBOARD_EN defined, simultaneous set and clear of the same address SHALL leave the bit set, and a grant to a non-busy address SHALL still be written.
REQ-030 Without RF_WARB_SCOREBOARD_EN, sb_busy SHALL be constant 0, sb_lock and sb_lock_addr SHALL be ignored, and no scoreboard flops SHALL be present.

Structure
REQ-031 Package rf_pkg SHALL hold DW, AW, NREQ defaults and requester id constants REQ_ALU=0, REQ_MEM=1, REQ_MOV=2.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector and last_grant in; one-hot grant and index out; combinational).

Verification
REQ-033 Bench scenario: reset, then req 0 valid with addr=3, data=0x5A for one cycle -> rf_we=1, rf_waddr=3, rf_wdata=0x5A, grant_id=0 for exactly one cycle, 2 edges after acceptance.
REQ-034 Bench scenario: all three requesters valid continuously with distinct data -> grants cycle 0,1,2,0,1,2, one write per cycle, each ready held high while granted.
REQ-035 Bench scenario: req 1 and req 2 both write addr=5 (0x11, then 0x22) in the same cycle -> two writes to 5, order by round-robin pointer, none dropped.
REQ-036 Bench scenario (RF_WARB_SCOREBOARD_EN): sb_lock addr=4 -> sb_busy[4]=1; later req 1 writes addr=4 -> bit clears at the grant edge; lock and grant of addr 4 in the same edge -> bit stays 1.
REQ-037 Bench scenario: reset pulsed with all three slots full -> rf_we=0, sb_busy=0, and no write appears after release.
REQ-038 Bench scenario: build without the macro, toggle sb_lock randomly -> sb_busy stays 0.
